// File: rtl/interrupt_ack_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : interrupt_ack_control                                        |
// | Description : 8259-style CPU acknowledge / in-service engine. Raises INT,  |
// |               runs the two-pulse INTA sequence, maintains ISR, pulses the   |
// |               IRR clear, drives the vector byte, handles EOI and owns the  |
// |               priority rotation pointer fed back to the resolver.          |
// | Options     : PIC_AUTO_EOI_EN - clear ISR automatically at the end of the  |
// |               second INTA pulse.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module interrupt_ack_control #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt_vector,
  input  logic [4:0] vector_base,
  input  logic       inta_n,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clr_irr,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       inta_q;
  logic       int_out_q, int_out_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clr_irr_q, clr_irr_d;
  logic [2:0] rotate_q, rotate_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic [2:0] ack_level_q, ack_level_d;
`ifdef PIC_AUTO_EOI_EN
  logic       spurious_q, spurious_d;
`endif

  logic       w_fall;
  logic       w_rise;
  logic [2:0] w_vec_level;
  logic [7:0] w_isr_eoi;
  logic [2:0] w_eoi_sel;
  logic       w_eoi_hit;
  logic [2:0] w_idx;

  assign w_fall = inta_q & ~inta_n;
  assign w_rise = ~inta_q & inta_n;

  // Encode the one-hot request into its IR level (lowest set bit wins if not one-hot).
  always_comb begin
    w_vec_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt_vector[i]) w_vec_level = i[2:0];
    end
  end

  // EOI resolution: pick the level being ended and produce the ISR after the clear.
  always_comb begin
    w_eoi_sel = 3'd0;
    w_eoi_hit = 1'b0;
    w_idx     = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        w_eoi_sel = eoi_level;
        w_eoi_hit = 1'b1;
      end else begin
        // Search from the current highest-priority level, wrapping mod 8.
        for (int i = 0; i < 8; i++) begin
          w_idx = rotate_q + i[2:0];
          if (!w_eoi_hit && isr_q[w_idx]) begin
            w_eoi_sel = w_idx;
            w_eoi_hit = 1'b1;
          end
        end
      end
    end
    w_isr_eoi = isr_q;
    if (w_eoi_hit) w_isr_eoi[w_eoi_sel] = 1'b0;
  end

  // Acknowledge FSM next state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out_q;
    isr_d       = w_isr_eoi;
    clr_irr_d   = 8'h00;
    rotate_d    = rotate_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    ack_level_d = ack_level_q;
`ifdef PIC_AUTO_EOI_EN
    spurious_d  = spurious_q;
`endif

    if (w_eoi_hit && rotate_on_eoi) rotate_d = w_eoi_sel + 3'd1;

    case (state_q)
      ST_IDLE: begin
        int_out_d = |interrupt_vector;
        if (w_fall) begin
          int_out_d = 1'b0;
          state_d   = ST_ACK1;
          if (interrupt_vector != 8'h00) begin
            ack_level_d = w_vec_level;
            // EOI clear has already been folded in, so a same-bit set wins.
            isr_d       = w_isr_eoi | interrupt_vector;
            clr_irr_d   = interrupt_vector;
`ifdef PIC_AUTO_EOI_EN
            spurious_d  = 1'b0;
`endif
          end else begin
            ack_level_d = SPURIOUS_LEVEL;
`ifdef PIC_AUTO_EOI_EN
            spurious_d  = 1'b1;
`endif
          end
        end
      end
      ST_ACK1: begin
        int_out_d = 1'b0;
        if (w_rise) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        int_out_d = 1'b0;
        if (w_fall) begin
          data_out_d = {vector_base, ack_level_q};
          data_oe_d  = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        int_out_d = 1'b0;
        if (w_rise) begin
          data_oe_d = 1'b0;
          state_d   = ST_IDLE;
`ifdef PIC_AUTO_EOI_EN
          if (!spurious_q) begin
            isr_d[ack_level_q] = 1'b0;
            if (rotate_on_eoi) rotate_d = ack_level_q + 3'd1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      inta_q      <= 1'b1;
      int_out_q   <= 1'b0;
      isr_q       <= 8'h00;
      clr_irr_q   <= 8'h00;
      rotate_q    <= 3'd0;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      ack_level_q <= 3'd0;
`ifdef PIC_AUTO_EOI_EN
      spurious_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      int_out_q   <= int_out_d;
      isr_q       <= isr_d;
      clr_irr_q   <= clr_irr_d;
      rotate_q    <= rotate_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      ack_level_q <= ack_level_d;
`ifdef PIC_AUTO_EOI_EN
      spurious_q  <= spurious_d;
`endif
    end
  end

  assign int_out         = int_out_q;
  assign isr             = isr_q;
  assign clr_irr         = clr_irr_q;
  assign priority_rotate = rotate_q;
  assign data_out        = data_out_q;
  assign data_oe         = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ack_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_interrupt_ack_control                                     |
// | Description : Self-checking bench for interrupt_ack_control with a         |
// |               behavioural ISR / rotation model and random stimulus.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_interrupt_ack_control;

  logic       clk;
  logic       reset;
  logic [7:0] interrupt_vector;
  logic [4:0] vector_base;
  logic       inta_n;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_oe;

  int total = 0;
  int bad   = 0;

  // Reference model state: in-service set and priority pointer.
  logic [7:0] m_isr;
  logic [2:0] m_rot;

  interrupt_ack_control dut (
    .clk              (clk),
    .reset            (reset),
    .interrupt_vector (interrupt_vector),
    .vector_base      (vector_base),
    .inta_n           (inta_n),
    .eoi_cmd          (eoi_cmd),
    .eoi_specific     (eoi_specific),
    .eoi_level        (eoi_level),
    .rotate_on_eoi    (rotate_on_eoi),
    .int_out          (int_out),
    .isr              (isr),
    .clr_irr          (clr_irr),
    .priority_rotate  (priority_rotate),
    .data_out         (data_out),
    .data_oe          (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of an EOI command: end the named level, or the first in-service level
  // found walking priorities upward from the pointer.
  task automatic model_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
    int l = -1;
    if (spec) l = lvl;
    else begin
      for (int k = 0; k < 8; k++) begin
        int idx = (m_rot + k) % 8;
        if (l < 0 && m_isr[idx]) l = idx;
      end
    end
    if (l >= 0) begin
      m_isr[l] = 1'b0;
      if (rot) m_rot = 3'((l + 1) % 8);
    end
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
    @(negedge clk);
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = lvl; rotate_on_eoi = rot;
    model_eoi(spec, lvl, rot);
    @(negedge clk);
    eoi_cmd = 1'b0; rotate_on_eoi = 1'b0;
    total++;
    if (isr !== m_isr) begin bad++; $display("FAIL eoi_isr got=%h want=%h", isr, m_isr); end
    total++;
    if (priority_rotate !== m_rot) begin
      bad++; $display("FAIL eoi_rot got=%0d want=%0d", priority_rotate, m_rot);
    end
  endtask

  // Full two-pulse acknowledge, optionally with an EOI in the first-fall cycle
  // and with the request line scrambled while the level is frozen.
  task automatic do_ack(input logic [7:0] vec, input logic [4:0] base,
                        input bit eoi_en, input bit eoi_spec, input logic [2:0] eoi_lvl,
                        input bit eoi_rot, input bit auto_rot, input bit scramble);
    logic [2:0] lvl;
    bit spur;
    @(negedge clk);
    interrupt_vector = vec; vector_base = base;
    @(negedge clk);
    total++;
    if (int_out !== (vec != 8'h00)) begin
      bad++; $display("FAIL int_out_raise got=%b want=%b", int_out, vec != 8'h00);
    end
    inta_n = 1'b0;
    if (eoi_en) begin
      eoi_cmd = 1'b1; eoi_specific = eoi_spec; eoi_level = eoi_lvl; rotate_on_eoi = eoi_rot;
      model_eoi(eoi_spec, eoi_lvl, eoi_rot);
    end
    spur = (vec == 8'h00);
    lvl = 3'd7;
    for (int i = 7; i >= 0; i--) if (vec[i]) lvl = 3'(i);
    if (!spur) m_isr = m_isr | vec;
    @(negedge clk);
    eoi_cmd = 1'b0; rotate_on_eoi = 1'b0;
    total++;
    if (clr_irr !== (spur ? 8'h00 : vec)) begin
      bad++; $display("FAIL clr_irr_pulse got=%h want=%h", clr_irr, spur ? 8'h00 : vec);
    end
    total++;
    if (isr !== m_isr) begin bad++; $display("FAIL isr_set got=%h want=%h", isr, m_isr); end
    total++;
    if (priority_rotate !== m_rot) begin
      bad++; $display("FAIL ack_rot got=%0d want=%0d", priority_rotate, m_rot);
    end
    total++;
    if (int_out !== 1'b0) begin bad++; $display("FAIL int_out_drop got=%b want=0", int_out); end
    if (scramble) interrupt_vector = 8'($urandom);
    @(negedge clk);
    total++;
    if (clr_irr !== 8'h00) begin bad++; $display("FAIL clr_irr_once got=%h want=00", clr_irr); end
    inta_n = 1'b1;
    @(negedge clk);
    total++;
    if (data_oe !== 1'b0 || int_out !== 1'b0) begin
      bad++; $display("FAIL wait2_quiet got oe=%b int=%b want 0 0", data_oe, int_out);
    end
    inta_n = 1'b0;
    if (scramble) interrupt_vector = 8'($urandom);
    @(negedge clk);
    total++;
    if (data_oe !== 1'b1 || data_out !== {base, lvl}) begin
      bad++; $display("FAIL drive_vec got oe=%b data=%h want oe=1 data=%h", data_oe, data_out, {base, lvl});
    end
    total++;
    if (int_out !== 1'b0) begin bad++; $display("FAIL int_out_drive got=%b want=0", int_out); end
    inta_n = 1'b1; rotate_on_eoi = auto_rot;
`ifdef PIC_AUTO_EOI_EN
    if (!spur) begin
      m_isr[lvl] = 1'b0;
      if (auto_rot) m_rot = lvl + 3'd1;
    end
`endif
    @(negedge clk);
    rotate_on_eoi = 1'b0;
    total++;
    if (data_oe !== 1'b0) begin bad++; $display("FAIL release got=%b want=0", data_oe); end
    total++;
    if (isr !== m_isr || priority_rotate !== m_rot) begin
      bad++; $display("FAIL end_state got isr=%h rot=%0d want isr=%h rot=%0d", isr, priority_rotate, m_isr, m_rot);
    end
    interrupt_vector = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; inta_n = 1'b1; interrupt_vector = 8'h00; vector_base = 5'd0;
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0;
    m_isr = 8'h00; m_rot = 3'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({int_out, isr, clr_irr, priority_rotate, data_out, data_oe} !== 28'h0) begin
      bad++; $display("FAIL reset_state got int=%b isr=%h clr=%h rot=%0d data=%h oe=%b want all 0",
                      int_out, isr, clr_irr, priority_rotate, data_out, data_oe);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_ack(8'h08, 5'b01000, 0, 0, 3'd0, 0, 0, 0);
`ifndef PIC_AUTO_EOI_EN
    total++;
    if (isr !== 8'h08) begin bad++; $display("FAIL basic_isr got=%h want=08", isr); end
`endif
    do_eoi(1, 3'd3, 0);
  endtask

  task automatic test_spurious();
    do_ack(8'h00, 5'b01000, 0, 0, 3'd0, 0, 0, 0);
    total++;
    if (isr !== 8'h00) begin bad++; $display("FAIL spurious_isr got=%h want=00", isr); end
  endtask

  task automatic test_nonspecific();
    m_isr = isr;
    do_ack(8'h04, 5'd3, 0, 0, 3'd0, 0, 0, 0);
    do_ack(8'h20, 5'd3, 0, 0, 3'd0, 0, 0, 0);
    do_eoi(0, 3'd0, 0);
`ifndef PIC_AUTO_EOI_EN
    total++;
    if (isr !== 8'h20) begin bad++; $display("FAIL nonspec_rot0 got=%h want=20", isr); end
`endif
    do_eoi(1, 3'd2, 1);     // pointer to 3
    do_ack(8'h04, 5'd3, 0, 0, 3'd0, 0, 0, 0);
    do_eoi(0, 3'd0, 0);
`ifndef PIC_AUTO_EOI_EN
    total++;
    if (isr !== 8'h04) begin bad++; $display("FAIL nonspec_rot3 got=%h want=04", isr); end
`endif
    do_eoi(0, 3'd0, 0);
    do_eoi(0, 3'd0, 0);     // empty ISR: no effect
  endtask

  task automatic test_specific_wrap();
    do_ack(8'h80, 5'd1, 0, 0, 3'd0, 0, 0, 0);
    do_eoi(1, 3'd7, 1);
    total++;
    if (isr !== 8'h00 || priority_rotate !== 3'd0) begin
      bad++; $display("FAIL spec_wrap got isr=%h rot=%0d want 00 0", isr, priority_rotate);
    end
  endtask

  task automatic test_collision();
    do_ack(8'h02, 5'd9, 0, 0, 3'd0, 0, 0, 0);
    do_ack(8'h02, 5'd9, 1, 1, 3'd1, 0, 0, 0);   // EOI on IR1 as IR1 is re-acked
    do_ack(8'h40, 5'd9, 1, 0, 3'd0, 1, 0, 0);
  endtask

  task automatic test_auto_eoi();
    do_ack(8'h20, 5'd2, 0, 0, 3'd0, 0, 1, 0);
`ifdef PIC_AUTO_EOI_EN
    total++;
    if (isr[5] !== 1'b0) begin bad++; $display("FAIL auto_eoi got=%b want=0", isr[5]); end
`else
    total++;
    if (isr[5] !== 1'b1) begin bad++; $display("FAIL no_auto_eoi got=%b want=1", isr[5]); end
`endif
  endtask

  task automatic test_reset_in_drive();
    @(negedge clk); interrupt_vector = 8'h02; vector_base = 5'd4;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk); inta_n = 1'b1;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk);
    total++;
    if (data_oe !== 1'b1) begin bad++; $display("FAIL pre_reset_drive got=%b want=1", data_oe); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (data_oe !== 1'b0 || isr !== 8'h00 || int_out !== 1'b0 || priority_rotate !== 3'd0) begin
      bad++; $display("FAIL async_reset got oe=%b isr=%h int=%b rot=%0d want 0 00 0 0",
                      data_oe, isr, int_out, priority_rotate);
    end
    inta_n = 1'b1; interrupt_vector = 8'h00;
    @(negedge clk); reset = 1'b0;
    m_isr = 8'h00; m_rot = 3'd0;
    do_ack(8'h10, 5'd6, 0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [7:0] v;
        v = ($urandom_range(0, 5) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        do_ack(v, 5'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
               3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end else begin
        do_eoi(1'($urandom), 3'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_nonspecific();
    test_specific_wrap();
    test_collision();
    test_auto_eoi();
    test_reset_in_drive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
